debounce_multi: RTL and testbench

//  Multi-channel debouncer for switches and buttons. Each channel has a 2-FF synchroniser and a stability counter.
//  A level is accepted only after the input holds it for a programmable interval.
//  Per channel it emits a debounced level plus one-cycle rise/fall strobes for the fabric (UI, SDAD control).

---
 rtl/debounce_multi_if.sv | 22 ++
 rtl/debounce_multi.sv | 126 ++++++++++++
 tb/tb_debounce_multi.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/debounce_multi_if.sv
// Bus bundle for debounce_multi: raw inputs towards the debouncer and the
// debounced levels/strobes back to the fabric.
interface debounce_multi_if #(
    parameter int unsigned C_CHANNELS = 4
);
    logic [C_CHANNELS-1:0] in_i;
    logic [C_CHANNELS-1:0] out_o;
    logic [C_CHANNELS-1:0] rise_o;
    logic [C_CHANNELS-1:0] fall_o;
    logic [C_CHANNELS-1:0] repeat_o;
    logic                  any_change_o;

    modport slave (
        input  in_i,
        output out_o, rise_o, fall_o, repeat_o, any_change_o
    );

    modport master (
        output in_i,
        input  out_o, rise_o, fall_o, repeat_o, any_change_o
    );
endinterface

// File: rtl/debounce_multi.sv
// Multi-channel switch/button debouncer: per channel a 2-FF synchroniser, a
// stability counter, a debounced level and one-cycle rise/fall strobes.
// Optional auto-repeat strobes are built only when DEBOUNCE_REPEAT_EN is defined.
module debounce_multi #(
    parameter int unsigned C_CHANNELS         = 4,
    parameter int unsigned C_CLK_FRQ          = 100000000,
    parameter int unsigned C_INTERVAL_US      = 10000,
    parameter bit          C_RESET_LEVEL      = 1'b0,
    parameter int unsigned C_REPEAT_DELAY_US  = 500000,
    parameter int unsigned C_REPEAT_PERIOD_US = 100000
) (
    input logic             clk,
    input logic             rst,
    debounce_multi_if.slave bus
);
    localparam longint unsigned C_CYCLES =
        (64'(C_CLK_FRQ) * 64'(C_INTERVAL_US)) / 64'd1000000;
    localparam int unsigned CNT_W = $clog2(C_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(C_CYCLES - 64'd1);
    localparam logic [C_CHANNELS-1:0] IDLE = {C_CHANNELS{C_RESET_LEVEL}};

    logic [C_CHANNELS-1:0] s1_q, s2_q, out_q;
    logic [C_CHANNELS-1:0] rise_q, fall_q;
    logic                  any_q;
    logic [CNT_W-1:0]      cnt_q [C_CHANNELS];
    logic [C_CHANNELS-1:0] accept_d, rise_d, fall_d;

    // Acceptance: synchronised level differs from output and counter is terminal
    always_comb begin
        accept_d = '0;
        for (int unsigned i = 0; i < C_CHANNELS; i++) begin
            accept_d[i] = (s2_q[i] != out_q[i]) && (cnt_q[i] == CNT_TERM);
        end
        rise_d = accept_d & (s2_q ^ IDLE);
        fall_d = accept_d & ~(s2_q ^ IDLE);
    end

    // Synchroniser, stability counters, debounced levels and registered strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= IDLE;
            s2_q   <= IDLE;
            out_q  <= IDLE;
            rise_q <= '0;
            fall_q <= '0;
            any_q  <= 1'b0;
            for (int unsigned i = 0; i < C_CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q   <= bus.in_i;
            s2_q   <= s1_q;
            rise_q <= rise_d;
            fall_q <= fall_d;
            any_q  <= |accept_d;
            for (int unsigned i = 0; i < C_CHANNELS; i++) begin
                if (s2_q[i] == out_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (accept_d[i]) begin
                    cnt_q[i] <= '0;
                    out_q[i] <= s2_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign bus.out_o        = out_q;
    assign bus.rise_o       = rise_q;
    assign bus.fall_o       = fall_q;
    assign bus.any_change_o = any_q;

`ifdef DEBOUNCE_REPEAT_EN
    localparam longint unsigned RPT_D =
        (64'(C_CLK_FRQ) * 64'(C_REPEAT_DELAY_US)) / 64'd1000000;
    localparam longint unsigned RPT_P =
        (64'(C_CLK_FRQ) * 64'(C_REPEAT_PERIOD_US)) / 64'd1000000;
    localparam longint unsigned RPT_MAX = (RPT_D > RPT_P) ? RPT_D : RPT_P;
    localparam int unsigned RPT_W = (RPT_MAX < 64'd2) ? 1 : $clog2(RPT_MAX);
    localparam logic [RPT_W-1:0] D_TERM = RPT_W'(RPT_D - 64'd1);
    localparam logic [RPT_W-1:0] P_TERM = RPT_W'(RPT_P - 64'd1);

    logic [RPT_W-1:0]      rcnt_q [C_CHANNELS];
    logic [C_CHANNELS-1:0] rphase_q, rpt_q, rpt_hit_d, pressed_d;

    // Repeat terminal count: initial delay first, then the repeat period
    always_comb begin
        rpt_hit_d = '0;
        pressed_d = out_q ^ IDLE;
        for (int unsigned i = 0; i < C_CHANNELS; i++) begin
            rpt_hit_d[i] = rphase_q[i] ? (rcnt_q[i] == P_TERM) : (rcnt_q[i] == D_TERM);
        end
    end

    // Repeat counters restart on every acceptance and run only while pressed
    always_ff @(posedge clk) begin
        if (rst) begin
            rphase_q <= '0;
            rpt_q    <= '0;
            for (int unsigned i = 0; i < C_CHANNELS; i++) begin
                rcnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < C_CHANNELS; i++) begin
                if (!pressed_d[i] || rise_d[i] || fall_d[i]) begin
                    rcnt_q[i]   <= '0;
                    rphase_q[i] <= 1'b0;
                    rpt_q[i]    <= 1'b0;
                end else if (rpt_hit_d[i]) begin
                    rcnt_q[i]   <= '0;
                    rphase_q[i] <= 1'b1;
                    rpt_q[i]    <= 1'b1;
                end else begin
                    rcnt_q[i]   <= rcnt_q[i] + RPT_W'(1);
                    rpt_q[i]    <= 1'b0;
                end
            end
        end
    end

    assign bus.repeat_o = rpt_q;
`else
    assign bus.repeat_o = '0;
`endif
endmodule

// File: tb/tb_debounce_multi.sv
module tb_debounce_multi;
    localparam int NCH = 4;
    localparam int CYC = 10;
    localparam int RD  = 30;
    localparam int RP  = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    debounce_multi_if #(.C_CHANNELS(NCH)) bus ();

    debounce_multi #(
        .C_CHANNELS(NCH), .C_CLK_FRQ(1000000), .C_INTERVAL_US(10),
        .C_RESET_LEVEL(1'b0), .C_REPEAT_DELAY_US(30), .C_REPEAT_PERIOD_US(10)
    ) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a level is accepted once the last CYC synchronised
    // samples all differ from the current output.
    logic [1:0]     m_pipe [NCH];
    logic [CYC-1:0] m_win  [NCH];
    int             m_fill [NCH];
    longint         m_rcyc [NCH];
    longint         cyc = 0;
    logic [NCH-1:0] m_out = '0, m_rise = '0, m_fall = '0, m_rep = '0;
    logic           m_any = 1'b0;

    always @(posedge clk) begin
        cyc++;
        m_rise = '0; m_fall = '0; m_rep = '0; m_any = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (rst) begin
                m_pipe[i] = '0; m_win[i] = '0; m_fill[i] = 0; m_out[i] = 1'b0;
            end else begin
                logic smp, acc;
                smp = m_pipe[i][1];
                m_win[i] = {m_win[i][CYC-2:0], smp};
                if (m_fill[i] < CYC) m_fill[i]++;
                acc = (m_fill[i] == CYC) && (m_win[i] == {CYC{~m_out[i]}});
`ifdef DEBOUNCE_REPEAT_EN
                if (!acc && m_out[i]) begin
                    longint el;
                    el = cyc - m_rcyc[i];
                    m_rep[i] = (el >= RD) && (((el - RD) % RP) == 0);
                end
`endif
                if (acc) begin
                    m_rise[i] = smp;
                    m_fall[i] = ~smp;
                    m_out[i]  = smp;
                    m_fill[i] = 0;
                    m_any     = 1'b1;
                    if (smp) m_rcyc[i] = cyc;
                end
                m_pipe[i] = {m_pipe[i][0], bus.in_i[i]};
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_out",  bus.out_o,        m_out);
            check("model_rise", bus.rise_o,       m_rise);
            check("model_fall", bus.fall_o,       m_fall);
            check("model_rep",  bus.repeat_o,     m_rep);
            check("model_any",  bus.any_change_o, m_any);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic wait_edge(input int ch, input bit want_rise, input int budget, output int n);
        n = -1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (want_rise ? bus.rise_o[ch] : bus.fall_o[ch]) begin
                n = k;
                break;
            end
        end
    endtask

    typedef struct {
        bit       rst;
        bit [3:0] in;
        bit [3:0] out;
        bit [3:0] rise;
        bit       any;
    } vec_t;

    vec_t tbl [17];

    initial begin
        int n, extra;
        int hold [NCH];

        // Reset with all inputs high, then a clean press on channel 0
        for (int i = 0; i < 17; i++) tbl[i] = '{1'b0, 4'h1, 4'h0, 4'h0, 1'b0};
        for (int i = 0; i < 3; i++)  tbl[i] = '{1'b1, 4'hF, 4'h0, 4'h0, 1'b0};
        tbl[3]  = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[15] = '{1'b0, 4'h1, 4'h1, 4'h1, 1'b1};
        tbl[16] = '{1'b0, 4'h1, 4'h1, 4'h0, 1'b0};

        bus.in_i = '0;
        for (int i = 0; i < 17; i++) begin
            rst = tbl[i].rst;
            bus.in_i = tbl[i].in;
            @(posedge clk);
            @(negedge clk);
            chk_en = 1'b1;
            check($sformatf("tbl%0d_out", i),  bus.out_o,        tbl[i].out);
            check($sformatf("tbl%0d_rise", i), bus.rise_o,       tbl[i].rise);
            check($sformatf("tbl%0d_fall", i), bus.fall_o,       4'h0);
            check($sformatf("tbl%0d_rep", i),  bus.repeat_o,     4'h0);
            check($sformatf("tbl%0d_any", i),  bus.any_change_o, tbl[i].any);
        end

        // Bounce on channel 1: 3, 5 and 9 cycle pulses are all rejected
        foreach (hold[i]) hold[i] = 0;
        hold[0] = 3; hold[1] = 5; hold[2] = 9;
        for (int p = 0; p < 3; p++) begin
            bus.in_i[1] = 1'b1; step(hold[p]);
            bus.in_i[1] = 1'b0; step(4);
        end
        check("bounce_out", bus.out_o[1], 1'b0);
        bus.in_i[1] = 1'b1;
        wait_edge(1, 1'b1, 40, n);
        check("bounce_latency", n, 12);

        // Concurrent press on channels 3:2, then channel 2 released alone
        bus.in_i[3:2] = 2'b11;
        wait_edge(2, 1'b1, 40, n);
        check("conc_latency", n, 12);
        check("conc_rise", bus.rise_o, 4'hC);
        check("conc_any", bus.any_change_o, 1'b1);
        bus.in_i[2] = 1'b0;
        wait_edge(2, 1'b0, 40, n);
        check("rel_latency", n, 12);
        check("rel_fall", bus.fall_o, 4'h4);
        check("rel_rise", bus.rise_o, 4'h0);
        check("rel_out3", bus.out_o[3], 1'b1);

        // Reset in the middle of a pending count
        bus.in_i = '0; step(14);
        bus.in_i[0] = 1'b1; step(7);
        check("midrst_pending", bus.out_o[0], 1'b0);
        rst = 1'b1; step(1);
        rst = 1'b0;
        wait_edge(0, 1'b1, 40, n);
        check("midrst_latency", n, 12);
        extra = 0;
        for (int k = 0; k < 30; k++) begin
            step(1);
            if (bus.rise_o[0]) extra++;
        end
        check("midrst_single_rise", extra, 0);

`ifdef DEBOUNCE_REPEAT_EN
        begin
            int reps [$];
            int fall_k;
            bus.in_i = '0; step(14);
            bus.in_i[0] = 1'b1;
            wait_edge(0, 1'b1, 40, n);
            check("rep_rise_latency", n, 12);
            fall_k = -1;
            for (int k = 1; k <= 100; k++) begin
                step(1);
                if (bus.repeat_o[0]) reps.push_back(k);
                if (bus.fall_o[0] && fall_k < 0) fall_k = k;
                if (k == 58) bus.in_i[0] = 1'b0;
            end
            check("rep_count", reps.size(), 4);
            for (int j = 0; j < reps.size() && j < 4; j++)
                check($sformatf("rep_at%0d", j), reps[j], 30 + 10 * j);
            check("rep_fall_at", fall_k, 70);
        end
`endif

        // Randomised hold lengths and occasional resets, checked by the model
        foreach (hold[i]) hold[i] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NCH; i++) begin
                if (hold[i] == 0) begin
                    bus.in_i[i] = 1'($urandom_range(0, 1));
                    hold[i] = $urandom_range(1, 60);
                end
                hold[i]--;
            end
            rst = ($urandom_range(0, 299) == 0);
            step(1);
        end
        rst = 1'b0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
